// File: rtl/booth_mul_arbiter_pkg.sv
// Shared types and default widths for the round-robin Booth multiplier scheduler.
package booth_mul_arbiter_pkg;

  localparam int unsigned DEF_DW = 6;
  localparam int unsigned DEF_PW = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/booth_mul_arbiter_booth_core.sv
// Combinational radix-2 Booth multiplier; product is full width, never truncated.
module booth_core
  import booth_mul_arbiter_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned PW = DEF_PW
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [PW-1:0] p_o
);

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] acc;
  logic                 prev;

  always_comb begin
    a_ext = PW'(a_i);
    acc   = '0;
    prev  = 1'b0;
    for (int unsigned i = 0; i < DW; i++) begin
      case ({b_i[i], prev})
        2'b01:   acc = acc + (a_ext <<< i);
        2'b10:   acc = acc - (a_ext <<< i);
        default: acc = acc;
      endcase
      prev = b_i[i];
    end
    p_o = acc;
  end

endmodule

// File: rtl/booth_mul_arbiter_rr_arbiter_n.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter_n #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand     = (32'(ptr_i) + k) % N;
      cand_idx = IW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one Booth core among N_REQ valid/ready requesters; tagged product on one response channel.
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned PW    = DEF_PW,
  parameter int unsigned IDW   = $clog2(N_REQ),
  parameter int unsigned CW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [PW-1:0]       rsp_product,
  output logic                busy,
  output logic [CW-1:0]       txn_count
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       id_q;
  logic signed [DW-1:0] op_a_q, op_b_q;
  logic                 rsp_valid_q;
  logic [IDW-1:0]       rsp_id_q;
  logic signed [PW-1:0] rsp_product_q;
  logic [CW-1:0]        txn_q;

  logic [N_REQ-1:0]     gnt;
  logic [IDW-1:0]       gnt_idx;
  logic                 gnt_any;
  logic signed [PW-1:0] core_p;
  logic                 accept_win;
  logic                 accept;
  logic                 rsp_hs;

  rr_arbiter_n #(
    .N  (N_REQ),
    .IW (IDW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  booth_core #(
    .DW (DW),
    .PW (PW)
  ) u_core (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (core_p)
  );

  assign rsp_hs = rsp_valid_q && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CALC;
      ST_CALC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = accept ? ST_CALC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Accepting in RESP on the response handshake keeps throughput at one product per 2 cycles.
  always_comb begin
    accept_win = !rst && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
    req_ready  = accept_win ? gnt : '0;
    accept     = accept_win && gnt_any;
    busy       = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      id_q          <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      txn_q         <= '0;
    end else begin
      if (accept) begin
        op_a_q   <= req_a[gnt_idx*DW +: DW];
        op_b_q   <= req_b[gnt_idx*DW +: DW];
        id_q     <= gnt_idx;
        rr_ptr_q <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state_q == ST_CALC) begin
        rsp_valid_q   <= 1'b1;
        rsp_id_q      <= id_q;
        rsp_product_q <= core_p;
      end else if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
      end
      if (rsp_hs && (txn_q != '1)) txn_q <= txn_q + 1'b1;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign txn_count   = txn_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter: expected {id, product} queued at stimulus, popped on handshake.
module tb_booth_mul_arbiter;

  localparam int N   = 4;
  localparam int DW  = 6;
  localparam int PW  = 12;
  localparam int IDW = 2;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a = '0;
  logic [N*DW-1:0]   req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [PW-1:0]     rsp_product;
  logic              busy;
  logic [CW-1:0]     txn_count;

  typedef logic [IDW+PW-1:0] exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mul_arbiter #(
    .N_REQ (N),
    .DW    (DW),
    .PW    (PW),
    .IDW   (IDW),
    .CW    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy),
    .txn_count   (txn_count)
  );

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL onehot: req_ready=%b, required at most one bit", req_ready);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: id=%0d product=%0d, required no response", rsp_id, $signed(rsp_product));
        end else begin
          mon_e = exp_q.pop_front();
          if ({rsp_id, rsp_product} !== mon_e) begin
            errors++;
            $display("FAIL rsp: id=%0d product=%0d, required id=%0d product=%0d",
                     rsp_id, $signed(rsp_product), mon_e[PW+IDW-1:PW], $signed(mon_e[PW-1:0]));
          end
        end
      end
    end
  end

  task automatic drive_op(input int i, input int a, input int b);
    req_a[i*DW +: DW] = DW'(a);
    req_b[i*DW +: DW] = DW'(b);
  endtask

  task automatic push_exp(input int id, input int a, input int b);
    exp_q.push_back({IDW'(id), PW'(a * b)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_ready: got %b, required 0000", req_ready);
    end
    checks++;
    if ({rsp_valid, busy, rsp_id, rsp_product} !== '0) begin
      errors++; $display("FAIL reset_outputs: valid=%b busy=%b id=%0d product=%0d, required all 0",
                         rsp_valid, busy, rsp_id, rsp_product);
    end
    checks++;
    if (txn_count !== '0) begin
      errors++; $display("FAIL reset_txn: got %0d, required 0", txn_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    drive_op(0, 6, 2);
    push_exp(0, 6, 2);
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_grant: got %b, required 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== 2'b01) begin
      errors++; $display("FAIL single_calc: valid=%b busy=%b, required valid=0 busy=1", rsp_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency: rsp_valid=%b, required 1", rsp_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, txn_count} !== {1'b0, 16'd1}) begin
      errors++; $display("FAIL single_done: valid=%b txn=%0d, required valid=0 txn=1", rsp_valid, txn_count);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    drive_op(2, -3, 5);
    push_exp(2, -3, 5);
    push_exp(1, -7, -6);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL b2b_grant2: got %b, required 0100", req_ready);
    end
    @(posedge clk); #1;
    drive_op(1, -7, -6);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL b2b_calc_ready: got %b, required 0000", req_ready);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== {1'b1, 4'b0010}) begin
      errors++; $display("FAIL b2b_hs_accept: valid=%b ready=%b, required valid=1 ready=0010", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drop: rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second: rsp_valid=%b, required 1", rsp_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (txn_count !== 16'd3) begin
      errors++; $display("FAIL b2b_txn: got %0d, required 3", txn_count);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    drive_op(3, 5, 5);
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL mid_grant: got %b, required 1000", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_rst_ready: got %b, required 0000", req_ready);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, txn_count} !== '0) begin
      errors++; $display("FAIL mid_rst_state: valid=%b busy=%b txn=%0d, required all 0", rsp_valid, busy, txn_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL mid_discard: rsp_valid=%b at cycle %0d, required 0", rsp_valid, c);
      end
    end
  endtask

  task automatic test_round_robin();
    int ra[4] = '{8, 15, -16, 30};
    int rb[4] = '{-4, 15, -16, -15};
    int order[5] = '{0, 1, 2, 3, 0};
    bit found;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) drive_op(i, ra[i], rb[i]);
    for (int k = 0; k < 5; k++) push_exp(order[k], ra[order[k]], rb[order[k]]);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        @(negedge clk);
        if (req_ready !== 4'b0000) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL rr_timeout: no grant for slot %0d, required grant %0d", k, order[k]);
      end else if (req_ready !== (4'b0001 << order[k])) begin
        errors++; $display("FAIL rr_order: slot %0d got %b, required grant %0d", k, req_ready, order[k]);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (txn_count !== 16'd5) begin
      errors++; $display("FAIL rr_txn: got %0d, required 5", txn_count);
    end
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive_op(1, -32, -32);
    drive_op(0, 2, 3);
    push_exp(1, -32, -32);
    push_exp(0, 2, 3);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL hold_grant: got %b, required 0010", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL hold_calc_ready: got %b, required 0000", req_ready);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_product, req_ready, txn_count} !== {1'b1, 2'd1, 12'd1024, 4'b0000, 16'd5}) begin
        errors++; $display("FAIL hold_stable: cycle %0d valid=%b id=%0d product=%0d ready=%b txn=%0d, required 1/1/1024/0000/5",
                           c, rsp_valid, rsp_id, $signed(rsp_product), req_ready, txn_count);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL hold_release_grant: got %b, required 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (txn_count !== 16'd6) begin
      errors++; $display("FAIL hold_txn: got %0d, required 6", txn_count);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (txn_count !== 16'd7) begin
      errors++; $display("FAIL hold_txn2: got %0d, required 7", txn_count);
    end
  endtask

  task automatic test_extremes();
    int order[2] = '{2, 3};
    bit found;
    @(posedge clk); #1;
    drive_op(3, -32, 31);
    drive_op(2, 31, 1);
    push_exp(2, 31, 1);
    push_exp(3, -32, 31);
    req_valid = 4'b1100;
    for (int k = 0; k < 2; k++) begin
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        @(negedge clk);
        if (req_ready !== 4'b0000) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL ext_timeout: no grant for slot %0d", k);
      end else if (req_ready !== (4'b0001 << order[k])) begin
        errors++; $display("FAIL ext_order: slot %0d got %b, required grant %0d", k, req_ready, order[k]);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (txn_count !== 16'd9) begin
      errors++; $display("FAIL ext_txn: got %0d, required 9", txn_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_round_robin();
    test_hold();
    test_extremes();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
